model_state_feedback_controller: RTL

MODEL_STATE_FEEDBACK_CONTROLLER -- requirements
Module: model_state_feedback_controller

---
 rtl/model_state_feedback_pkg.sv | 16 +
 rtl/model_state_feedback_accumulator.sv | 36 +++
 rtl/model_state_feedback_controller.sv | 123 ++++++++++++
 3 files changed

// File: rtl/model_state_feedback_pkg.sv
// Purpose: shared defaults and FSM state encoding for the state-feedback controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package model_state_feedback_pkg;

    localparam int DATA_SIZE_DEFAULT    = 64;
    localparam int CONTROL_SIZE_DEFAULT = 64;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_FETCH = 2'd1;
    localparam state_t ST_EMIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/model_state_feedback_accumulator.sv
// Purpose: unsigned multiply-accumulate register, result wraps modulo 2^DATA_SIZE.
// Latency: operands folded into result on the same rising edge that samples enable.
// Backpressure: none; caller gates enable. Clear has priority over enable.
// Ports: clk, rst (sync active-low), clear, enable, op_a, op_b, result.
module model_state_feedback_accumulator
    import model_state_feedback_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [DATA_SIZE-1:0] op_a,
    input  logic [DATA_SIZE-1:0] op_b,
    output logic [DATA_SIZE-1:0] result
);

    logic [DATA_SIZE-1:0] acc;
    logic [DATA_SIZE-1:0] product_lo;

    // Evaluated at DATA_SIZE width, so only the low half of the product is kept.
    assign product_lo = op_a * op_b;
    assign result     = acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + product_lo;
        end
    end

endmodule

// File: rtl/model_state_feedback_controller.sv
// Purpose: computes u[i] = sum_j K[i][j]*x[j] row by row, fetching one operand pair per cycle.
// Latency: SIZE_I*(SIZE_J+1)+1 cycles from START edge to READY when operands arrive every cycle.
// Backpressure: FETCH stalls with indices held until ELEMENT_VALID; outputs cannot be stalled.
// Ports: CLK, RST (sync active-low), START/READY handshake, SIZE_I_IN/SIZE_J_IN,
//        ELEMENT_REQ/INDEX_I_OUT/INDEX_J_OUT/ELEMENT_VALID/MATRIX_IN/VECTOR_IN operand fetch,
//        DATA_OUT/DATA_OUT_ENABLE/DATA_INDEX_OUT row results.
module model_state_feedback_controller
    import model_state_feedback_pkg::*;
#(
    parameter int DATA_SIZE    = DATA_SIZE_DEFAULT,
    parameter int CONTROL_SIZE = CONTROL_SIZE_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
    input  logic [CONTROL_SIZE-1:0] SIZE_J_IN,
    output logic                    ELEMENT_REQ,
    output logic [CONTROL_SIZE-1:0] INDEX_I_OUT,
    output logic [CONTROL_SIZE-1:0] INDEX_J_OUT,
    input  logic                    ELEMENT_VALID,
    input  logic [DATA_SIZE-1:0]    MATRIX_IN,
    input  logic [DATA_SIZE-1:0]    VECTOR_IN,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    DATA_OUT_ENABLE,
    output logic [CONTROL_SIZE-1:0] DATA_INDEX_OUT
);

    localparam logic [CONTROL_SIZE-1:0] CTRL_ONE = CONTROL_SIZE'(1);

    state_t                  state;
    logic [CONTROL_SIZE-1:0] size_i;
    logic [CONTROL_SIZE-1:0] size_j;
    logic [CONTROL_SIZE-1:0] idx_i;
    logic [CONTROL_SIZE-1:0] idx_j;
    logic [DATA_SIZE-1:0]    last_data;
    logic [DATA_SIZE-1:0]    acc_value;
    logic                    acc_clear;
    logic                    acc_enable;
    logic                    last_i;
    logic                    last_j;

    assign last_i = (idx_i == size_i - CTRL_ONE);
    assign last_j = (idx_j == size_j - CTRL_ONE);

    // Cleared when a run starts and after every row is emitted; ELEMENT_VALID
    // only counts while an operand is actually being requested.
    assign acc_clear  = ((state == ST_IDLE) && START) || (state == ST_EMIT);
    assign acc_enable = (state == ST_FETCH) && ELEMENT_VALID;

    model_state_feedback_accumulator #(
        .DATA_SIZE (DATA_SIZE)
    ) u_acc (
        .clk    (CLK),
        .rst    (RST),
        .clear  (acc_clear),
        .enable (acc_enable),
        .op_a   (MATRIX_IN),
        .op_b   (VECTOR_IN),
        .result (acc_value)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= ST_IDLE;
            size_i    <= '0;
            size_j    <= '0;
            idx_i     <= '0;
            idx_j     <= '0;
            last_data <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        size_i <= SIZE_I_IN;
                        size_j <= SIZE_J_IN;
                        idx_i  <= '0;
                        idx_j  <= '0;
                        // An empty matrix has nothing to fetch or emit.
                        if ((SIZE_I_IN == '0) || (SIZE_J_IN == '0)) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (ELEMENT_VALID) begin
                        if (last_j) begin
                            state <= ST_EMIT;
                        end else begin
                            idx_j <= idx_j + CTRL_ONE;
                        end
                    end
                end
                ST_EMIT: begin
                    last_data <= acc_value;
                    idx_j     <= '0;
                    if (last_i) begin
                        state <= ST_DONE;
                    end else begin
                        idx_i <= idx_i + CTRL_ONE;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign READY           = (state == ST_DONE);
    assign ELEMENT_REQ     = (state == ST_FETCH);
    assign INDEX_I_OUT     = idx_i;
    assign INDEX_J_OUT     = idx_j;
    assign DATA_OUT_ENABLE = (state == ST_EMIT);
    // The finished sum is shown live during EMIT and held afterwards.
    assign DATA_OUT        = (state == ST_EMIT) ? acc_value : last_data;
    assign DATA_INDEX_OUT  = (state == ST_EMIT) ? idx_i : '0;

endmodule
